// File: rtl/reg_write_arbiter.sv
// Two-requester write-port arbiter for an enable-gated register bank: one write every two cycles.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins); default is round-robin.
module reg_write_arbiter #(
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned ADDR_W   = 2
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                REQ0,
   input  logic [ADDR_W-1:0]   ADDR0,
   input  logic [DATA_W-1:0]   DATA0,
   output logic                ACK0,
   input  logic                REQ1,
   input  logic [ADDR_W-1:0]   ADDR1,
   input  logic [DATA_W-1:0]   DATA1,
   output logic                ACK1,
   output logic [NUM_REGS-1:0] REG_EN,
   output logic [DATA_W-1:0]   REG_DIN,
   output logic                BUSY,
   output logic                ADDR_ERR
);

   localparam int unsigned SLOTS = 2 ** ADDR_W;
   localparam logic [SLOTS-1:0] VALID_MASK = SLOTS'((64'(1) << NUM_REGS) - 64'(1));

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
   logic [DATA_W-1:0]   reg_din_q, reg_din_d;
   logic                busy_q, busy_d;
   logic                addr_err_q, addr_err_d;

   logic                grant1;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic [SLOTS-1:0]    decode;

`ifdef ARB_FIXED_PRIORITY_EN
   // Requester 0 always wins a tie; requester 1 only wins when alone.
   always_comb begin
      grant1 = REQ1 & ~REQ0;
   end
`else
   logic ptr_q, ptr_d;

   // Pointer names the preferred requester on a tie; a lone request always wins.
   always_comb begin
      grant1 = REQ1 & (~REQ0 | ptr_q);
      ptr_d  = ptr_q;
      if ((state_q == IDLE) && (REQ0 | REQ1)) begin
         ptr_d = ~grant1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Winner selection, address decode and next-state/output logic.
   always_comb begin
      sel_addr   = grant1 ? ADDR1 : ADDR0;
      sel_data   = grant1 ? DATA1 : DATA0;
      decode     = SLOTS'(1) << sel_addr;

      state_d    = IDLE;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      reg_en_d   = '0;
      reg_din_d  = '0;
      busy_d     = 1'b0;
      addr_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (REQ0 | REQ1) begin
               state_d    = WRITE;
               ack0_d     = ~grant1;
               ack1_d     = grant1;
               reg_en_d   = NUM_REGS'(decode & VALID_MASK);
               reg_din_d  = sel_data;
               busy_d     = 1'b1;
               addr_err_d = ~|(decode & VALID_MASK);
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         reg_en_q   <= '0;
         reg_din_q  <= '0;
         busy_q     <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         reg_en_q   <= reg_en_d;
         reg_din_q  <= reg_din_d;
         busy_q     <= busy_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign ACK0     = ack0_q;
   assign ACK1     = ack1_q;
   assign REG_EN   = reg_en_q;
   assign REG_DIN  = reg_din_q;
   assign BUSY     = busy_q;
   assign ADDR_ERR = addr_err_q;

endmodule
